// File: rtl/mac_sched_pkg.sv
// Shared types and widths for the MAC job scheduler.
package mac_sched_pkg;
  localparam int MAC_LATENCY = 3;
  localparam int ACC_W       = 32;
  localparam int OP_W        = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RECOVER,
    S_ISSUE,
    S_START,
    S_WAIT,
    S_SETTLE,
    S_RESULT
  } state_t;
endpackage

// File: rtl/mac_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, cyclically.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);
  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/mac_job_scheduler.sv
// Shares one MAC among NREQ requesters: per job clear, issue each (A,B) pair,
// then return the dot product with id, element count and sticky overflow.
module mac_job_scheduler
  import mac_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDW-1:0]       res_id,
  output logic [ACC_W-1:0]     res_data,
  output logic                 res_ovf,
  output logic [CNTW-1:0]      res_count,
  output logic                 mac_rst,
  output logic                 mac_valid,
  output logic [OP_W-1:0]      mac_a,
  output logic [OP_W-1:0]      mac_b,
  input  logic [ACC_W-1:0]     mac_y,
  input  logic                 mac_overflow,
  input  logic                 mac_done,
  output logic                 busy
);
  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d, g_q, g_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]  res_data_q, res_data_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic              ovf_q, ovf_d, last_q, last_d, clr_q, clr_d;
  logic              mac_valid_q, mac_valid_d, res_valid_q, res_valid_d;
  logic              busy_q, busy_d;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (state_q == S_IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    int sel;
    sel         = int'(g_q);
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    last_d      = last_q;
    ovf_d       = ovf_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    clr_d       = 1'b0;
    mac_valid_d = 1'b0;
    req_ready_d = '0;
    case (state_q)
      S_IDLE: if (|gnt) begin
        g_d     = gnt_idx;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        clr_d   = 1'b1;
        state_d = S_CLEAR;
      end
      S_CLEAR:   state_d = S_RECOVER;
      S_RECOVER: begin
        req_ready_d[g_q] = 1'b1;
        state_d          = S_ISSUE;
      end
      S_ISSUE: if (req_valid[g_q]) begin
        a_d         = req_a[sel*OP_W +: OP_W];
        b_d         = req_b[sel*OP_W +: OP_W];
        last_d      = req_last[g_q];
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        mac_valid_d = 1'b1;
        state_d     = S_START;
      end else begin
        // Grant stays locked to g while its requester stalls.
        req_ready_d[g_q] = 1'b1;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: if (mac_done) begin
        ovf_d   = ovf_q | mac_overflow;
        state_d = S_SETTLE;
      end
      S_SETTLE: if (last_q) begin
        res_data_d  = mac_y;
        res_valid_d = 1'b1;
        state_d     = S_RESULT;
      end else begin
        req_ready_d[g_q] = 1'b1;
        state_d          = S_ISSUE;
      end
      S_RESULT: if (res_ready) begin
        res_valid_d = 1'b0;
        ptr_d       = (int'(g_q) == NREQ - 1) ? '0 : g_q + 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      last_q      <= 1'b0;
      ovf_q       <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      clr_q       <= 1'b0;
      mac_valid_q <= 1'b0;
      req_ready_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      last_q      <= last_d;
      ovf_q       <= ovf_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      clr_q       <= clr_d;
      mac_valid_q <= mac_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign res_id    = g_q;
  assign res_data  = res_data_q;
  assign res_ovf   = ovf_q;
  assign res_count = cnt_q;
  // clr_q is a flop, so the MAC reset pulse is glitch-free.
  assign mac_rst   = reset | clr_q;
  assign mac_valid = mac_valid_q;
  assign mac_a     = a_q;
  assign mac_b     = b_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_mac_job_scheduler.sv
// Scheduler bench: behavioural MAC, job-level scoreboard, directed and random traffic.
module tb_mac_job_scheduler;
  import mac_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 8;
  localparam int CMAX = 2**CNTW - 1;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic              clk, reset;
  logic [NREQ-1:0]   req_valid, req_last, req_ready;
  logic [NREQ*8-1:0] req_a, req_b;
  logic              res_valid, res_ready, res_ovf;
  logic [IDW-1:0]    res_id;
  logic [31:0]       res_data;
  logic [CNTW-1:0]   res_count;
  logic              mac_rst, mac_valid, mac_overflow, mac_done, busy;
  logic [7:0]        mac_a, mac_b;
  logic [31:0]       mac_y;

  mac_job_scheduler #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_last(req_last), .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_data(res_data), .res_ovf(res_ovf), .res_count(res_count),
    .mac_rst(mac_rst), .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b), .mac_y(mac_y),
    .mac_overflow(mac_overflow), .mac_done(mac_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural MAC: samples valid when idle, loads operands next cycle,
  // pulses done two cycles after that, updates y the cycle after done.
  logic [31:0]       mac_preset = 32'd0;
  logic              m_busy;
  logic [1:0]        m_cnt;
  logic signed [7:0] m_a, m_b;
  wire signed [15:0] m_prod = m_a * m_b;

  function automatic logic add_ovf(input logic [31:0] y, input logic signed [15:0] p);
    longint s = longint'($signed(y)) + longint'(p);
    return (s > SMAX) || (s < SMIN);
  endfunction

  always @(posedge clk or posedge mac_rst) begin
    if (mac_rst) begin
      m_busy <= 1'b0; m_cnt <= 2'd0; mac_done <= 1'b0; mac_overflow <= 1'b0;
      mac_y <= mac_preset; m_a <= '0; m_b <= '0;
    end else begin
      mac_done     <= 1'b0;
      mac_overflow <= 1'b0;
      if (!m_busy) begin
        if (mac_valid) begin m_busy <= 1'b1; m_cnt <= 2'd0; end
      end else begin
        m_cnt <= m_cnt + 2'd1;
        case (m_cnt)
          2'd0: begin m_a <= mac_a; m_b <= mac_b; end
          2'd1: begin mac_done <= 1'b1; mac_overflow <= add_ovf(mac_y, m_prod); end
          default: begin mac_y <= mac_y + 32'(m_prod); m_busy <= 1'b0; end
        endcase
      end
    end
  end

  typedef struct { logic [7:0] a; logic [7:0] b; logic last; } elem_t;
  typedef struct { int id; logic [31:0] data; int cnt; logic ovf; int lat; } res_t;

  elem_t jq [NREQ][$];
  res_t  res_log[$];
  res_t  exp_q[$];

  int            drop_pct = 0;
  bit            rdy_rand = 0;
  logic          res_ready_fix = 1'b1;
  logic [NREQ-1:0] hs = '0;

  // Requester/consumer driver: presents the head element of each queue.
  initial begin
    req_valid = '0; req_last = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i] && jq[i].size() > 0) void'(jq[i].pop_front());
        if (jq[i].size() > 0 && $urandom_range(0, 99) >= drop_pct) begin
          req_valid[i]       = 1'b1;
          req_a[i*8 +: 8]    = jq[i][0].a;
          req_b[i*8 +: 8]    = jq[i][0].b;
          req_last[i]        = jq[i][0].last;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      res_ready = rdy_rand ? ($urandom_range(0, 99) < 70) : res_ready_fix;
    end
  end

  // Job-level reference model and per-cycle checker.
  int              cyc = 0, owner = -1, ptr_m = 0, grant_cyc = 0, cur_lat = 0, mac_valid_cnt = 0;
  longint          sum = 0, s = 0;
  int              cnt = 0, p = 0;
  bit              ovf = 0, busy_prev = 0, hold_prev = 0, rv_prev = 0;
  logic [NREQ-1:0] vld_prev = '0, omask;
  logic [31:0]     w, pd;
  logic [IDW-1:0]  pid;
  logic [CNTW-1:0] pc;
  logic            po;
  res_t            e, r;

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      owner = -1; ptr_m = 0; exp_q.delete(); hs = '0;
      busy_prev = 0; hold_prev = 0; rv_prev = 0; vld_prev = req_valid;
    end else begin
      if (busy && !busy_prev) begin
        owner = rr_pick(vld_prev, ptr_m);
        chk("grant_has_requester", owner >= 0, 1);
        sum = longint'($signed(mac_preset)); cnt = 0; ovf = 0; grant_cyc = cyc;
      end
      omask = (owner >= 0) ? (NREQ'(1) << owner) : '0;
      chk("ready_owner_only", req_ready & ~omask, 0);
      if (res_valid) begin
        chk("ready_during_result", req_ready, 0);
        chk("mac_valid_during_result", mac_valid, 0);
      end
      hs = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) begin
          chk("accept_owner", i, owner);
          p = int'($signed(req_a[i*8 +: 8])) * int'($signed(req_b[i*8 +: 8]));
          s = sum + longint'(p);
          if (s > SMAX || s < SMIN) ovf = 1;
          w = s[31:0];
          sum = longint'($signed(w));
          if (cnt < CMAX) cnt++;
          if (req_last[i]) begin
            e.id = owner; e.data = w; e.cnt = cnt; e.ovf = ovf; e.lat = 0;
            exp_q.push_back(e);
          end
        end
      end
      if (hold_prev) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_data", $signed(res_data), $signed(pd));
        chk("hold_id", res_id, pid);
        chk("hold_count", res_count, pc);
        chk("hold_ovf", res_ovf, po);
      end
      if (res_valid && !rv_prev) cur_lat = cyc - grant_cyc + 1;
      if (res_valid && res_ready) begin
        chk("result_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("res_id", res_id, e.id);
          chk("res_data", $signed(res_data), $signed(e.data));
          chk("res_count", res_count, e.cnt);
          chk("res_ovf", res_ovf, e.ovf);
        end
        r.id = int'(res_id); r.data = res_data; r.cnt = int'(res_count); r.ovf = res_ovf; r.lat = cur_lat;
        res_log.push_back(r);
        ptr_m = (owner + 1) % NREQ;
        owner = -1;
      end
      hold_prev = res_valid && !res_ready;
      pd = res_data; pid = res_id; pc = res_count; po = res_ovf;
      busy_prev = busy; vld_prev = req_valid; rv_prev = res_valid;
      if (mac_valid) mac_valid_cnt++;
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_elem(input int rq, input int a, input int b, input bit last);
    elem_t el;
    el.a = 8'(a); el.b = 8'(b); el.last = last;
    jq[rq].push_back(el);
  endtask

  task automatic wait_res(input int n, input int budget);
    int k = 0;
    while (res_log.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #2;
    if (res_log.size() < n) begin
      n_chk++; n_fail++;
      $display("FAIL wait_result: got %0d results expected %0d", res_log.size(), n);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_mac_valid"}, mac_valid, 0);
    chk({tag, "_mac_a"}, mac_a, 0);
    chk({tag, "_mac_b"}, mac_b, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_id"}, res_id, 0);
    chk({tag, "_res_count"}, res_count, 0);
    chk({tag, "_res_ovf"}, res_ovf, 0);
    chk({tag, "_mac_rst"}, mac_rst, 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc_n(2);
    reset = 1'b0;
    cyc_n(1);
  endtask

  initial begin
    int b, k, njobs, base;
    reset = 1'b1;
    cyc_n(2);
    @(negedge clk);
    check_zero("reset");
    cyc_n(1);
    reset = 1'b0;
    cyc_n(1);

    // Three-element job from requester 0.
    b = res_log.size();
    push_elem(0, 3, 4, 0); push_elem(0, -2, 5, 0); push_elem(0, 7, -1, 1);
    wait_res(b + 1, 200);
    if (res_log.size() > b) begin
      chk("A_data", $signed(res_log[b].data), -5);
      chk("A_count", res_log[b].cnt, 3);
      chk("A_id", res_log[b].id, 0);
      chk("A_ovf", res_log[b].ovf, 0);
      chk("A_latency", res_log[b].lat, 21);
    end

    // Two simultaneous single-element jobs; second must not see the first's sum.
    pulse_reset();
    b = res_log.size();
    push_elem(0, 1, 1, 1); push_elem(1, 2, 2, 1);
    wait_res(b + 2, 200);
    if (res_log.size() > b + 1) begin
      chk("B0_id", res_log[b].id, 0);
      chk("B0_data", $signed(res_log[b].data), 1);
      chk("B0_latency", res_log[b].lat, 9);
      chk("B1_id", res_log[b+1].id, 1);
      chk("B1_data", $signed(res_log[b+1].data), 4);
    end

    // All four requesters continuously valid: strict rotation.
    pulse_reset();
    b = res_log.size();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NREQ; i++) push_elem(i, i + 1, 1, 1);
    wait_res(b + 8, 400);
    if (res_log.size() >= b + 8)
      for (int j = 0; j < 8; j++) begin
        chk("C_order", res_log[b+j].id, j % NREQ);
        chk("C_data", $signed(res_log[b+j].data), (j % NREQ) + 1);
      end

    // Consumer backpressure for 5 cycles.
    res_ready_fix = 1'b0;
    cyc_n(2);
    b = res_log.size();
    push_elem(2, 3, -3, 1);
    k = 0;
    while (!res_valid && k < 100) begin @(negedge clk); k++; end
    chk("D_res_valid_seen", res_valid, 1);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("D_stall_valid", res_valid, 1);
      chk("D_stall_data", $signed(res_data), -9);
      chk("D_stall_id", res_id, 2);
      chk("D_stall_ready", req_ready, 0);
      chk("D_stall_mac_valid", mac_valid, 0);
    end
    res_ready_fix = 1'b1;
    wait_res(b + 1, 20);
    @(negedge clk);
    chk("D_idle_after", busy, 0);
    chk("D_valid_drop", res_valid, 0);
    cyc_n(1);

    // Long job: MAC starts near the positive limit so the sum wraps; count saturates.
    mac_preset = 32'h7FFF_0000;
    b = res_log.size();
    for (int j = 0; j < 300; j++) push_elem(2, -128, -128, j == 299);
    wait_res(b + 1, 2500);
    if (res_log.size() > b) begin
      chk("E_ovf", res_log[b].ovf, 1);
      chk("E_count", res_log[b].cnt, 255);
      chk("E_data", $signed(res_log[b].data), -64'sd2142633984);
      chk("E_id", res_log[b].id, 2);
    end
    mac_preset = 32'd0;
    cyc_n(1);

    // Reset while waiting on the MAC for the second element of a req1 job.
    base = mac_valid_cnt;
    push_elem(1, 1, 1, 0); push_elem(1, 2, 2, 0); push_elem(1, 3, 3, 1);
    k = 0;
    while (mac_valid_cnt < base + 2 && k < 200) begin @(negedge clk); k++; end
    chk("F_second_issue_seen", mac_valid_cnt, base + 2);
    @(posedge clk); #2;
    reset = 1'b1;
    jq[1].delete();
    @(negedge clk);
    check_zero("F_reset");
    cyc_n(2);
    reset = 1'b0;
    cyc_n(1);
    b = res_log.size();
    push_elem(1, 5, 5, 1);
    wait_res(b + 1, 200);
    if (res_log.size() > b) begin
      chk("F_data", $signed(res_log[b].data), 25);
      chk("F_id", res_log[b].id, 1);
      chk("F_count", res_log[b].cnt, 1);
    end

    // Random traffic with requester stalls and consumer backpressure.
    drop_pct = 20;
    rdy_rand = 1;
    b = res_log.size();
    njobs = 0;
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 8; j++) begin
        k = $urandom_range(1, 4);
        for (int m = 0; m < k; m++)
          push_elem(i, $urandom_range(0, 255), $urandom_range(0, 255), m == k - 1);
        njobs++;
      end
    wait_res(b + njobs, 20000);
    rdy_rand = 0;
    cyc_n(4);
    chk("random_all_retired", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
